// File: rtl/isp_program_loader_pkg.sv
// Shared definitions for the ISP program loader: frame geometry and FSM state encoding.
package isp_program_loader_pkg;

  // Header is count16 + entry16; payload words are 4 bytes, little-endian.
  localparam int unsigned FRAME_HDR_BYTES = 4;
  localparam int unsigned WORD_BYTES      = 4;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StWrite,
    StCsum,
    StLaunch,
    StDone,
    StError
  } state_e;

endpackage

// File: rtl/isp_program_loader_if.sv
// Loader bus bundle: byte stream in (rx_*), instruction-memory write port (isp_*),
// and core control (core_reset, start, prog_address).
//   master : the loader side (consumes rx bytes, drives memory/core pins)
//   slave  : the host/core side
interface isp_program_loader_if #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 12
);

  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic                    rx_ready;
  logic                    isp_write;
  logic [ADDRESS_BITS-1:0] isp_address;
  logic [DATA_WIDTH-1:0]   isp_data;
  logic                    core_reset;
  logic                    start;
  logic [19:0]             prog_address;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, isp_write, isp_address, isp_data, core_reset, start, prog_address
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, isp_write, isp_address, isp_data, core_reset, start, prog_address
  );

endinterface

// File: rtl/isp_word_assembler.sv
// Shifts payload bytes (LSB first) into a word register.
//   clk_i, rst_ni  : clock, async active-low reset
//   clear_i        : sync clear of counter, word and strobe
//   byte_valid_i   : byte_i is consumed this cycle
//   last_byte_o    : the next consumed byte completes the word
//   word_o         : assembled word
//   word_valid_o   : one-cycle pulse the cycle after the word completes
module isp_word_assembler
  import isp_program_loader_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      byte_valid_i,
  input  logic [7:0]                byte_i,
  output logic                      last_byte_o,
  output logic [WORD_BYTES*8-1:0]   word_o,
  output logic                      word_valid_o
);

  logic [1:0]              cnt_q, cnt_d;
  logic [WORD_BYTES*8-1:0] word_q, word_d;
  logic                    valid_q, valid_d;

  assign last_byte_o  = (cnt_q == 2'(WORD_BYTES - 1));
  assign word_o       = word_q;
  assign word_valid_o = valid_q;

  always_comb begin
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear_i) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (byte_valid_i) begin
      // Shift right so the first byte ends up in bits [7:0].
      word_d  = {byte_i, word_q[WORD_BYTES*8-1:8]};
      cnt_d   = cnt_q + 2'd1;
      valid_d = last_byte_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/isp_program_loader.sv
// In-system-programming loader. Parses [count16][entry16][count x word32][xor8],
// writes words to instruction memory at 0..count-1, and on a good checksum releases
// the core and pulses start with prog_address = {entry, 2'b00}.
//   clock, reset      : clock, async active-low reset
//   bus (master)      : rx byte stream, isp write port, core control
//   clear             : leaves DONE/ERROR back to IDLE
//   busy, done, error : status flags
module isp_program_loader
  import isp_program_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 12
) (
  input  logic                 clock,
  input  logic                 reset,
  isp_program_loader_if.master bus,
  input  logic                 clear,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int unsigned Depth = 1 << ADDRESS_BITS;
  localparam int unsigned IdxW  = ADDRESS_BITS + 1;

  state_e                  state_q, state_d;
  logic [15:0]             count_q, count_d;
  logic [15:0]             entry_q, entry_d;
  logic [1:0]              hdr_cnt_q, hdr_cnt_d;
  logic [IdxW-1:0]         index_q, index_d;  // one extra bit so count == Depth fits
  logic [7:0]              csum_q, csum_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [19:0]             prog_q, prog_d;
  logic rx_ready_q, rx_ready_d, busy_q, busy_d, done_q, done_d;
  logic error_q, error_d, core_reset_q, core_reset_d, start_q, start_d;

  logic                    xfer, asm_clear, asm_valid, asm_last, asm_word_valid;
  logic [WORD_BYTES*8-1:0] asm_word;

  assign xfer      = bus.rx_valid & rx_ready_q;
  assign asm_valid = xfer & (state_q == StData);
  assign asm_clear = clear & ((state_q == StDone) | (state_q == StError));

  isp_word_assembler u_asm (
    .clk_i       (clock),
    .rst_ni      (reset),
    .clear_i     (asm_clear),
    .byte_valid_i(asm_valid),
    .byte_i      (bus.rx_data),
    .last_byte_o (asm_last),
    .word_o      (asm_word),
    .word_valid_o(asm_word_valid)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    entry_d   = entry_q;
    hdr_cnt_d = hdr_cnt_q;
    index_d   = index_q;
    csum_d    = csum_q;
    addr_d    = addr_q;
    prog_d    = prog_q;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          count_d   = {8'h00, bus.rx_data};
          hdr_cnt_d = 2'd1;
          csum_d    = bus.rx_data;
          index_d   = '0;
          state_d   = StHdr;
        end
      end
      StHdr: begin
        if (xfer) begin
          csum_d    = csum_q ^ bus.rx_data;
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          case (hdr_cnt_q)
            2'd1:    count_d[15:8] = bus.rx_data;
            2'd2:    entry_d[7:0]  = bus.rx_data;
            default: entry_d[15:8] = bus.rx_data;
          endcase
          if (hdr_cnt_q == 2'(FRAME_HDR_BYTES - 1)) begin
            if (32'(count_q) > Depth || 32'({bus.rx_data, entry_q[7:0]}) >= Depth) begin
              state_d = StError;
            end else if (count_q == 16'd0) begin
              state_d = StCsum;
            end else begin
              state_d = StData;
            end
          end
        end
      end
      StData: begin
        if (xfer) begin
          csum_d = csum_q ^ bus.rx_data;
          if (asm_last) begin
            addr_d  = index_q[ADDRESS_BITS-1:0];
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        index_d = index_q + IdxW'(1);
        state_d = (32'(index_q) + 32'd1 == 32'(count_q)) ? StCsum : StData;
      end
      StCsum: begin
        if (xfer) begin
          if (bus.rx_data == csum_q) begin
            prog_d  = 20'({entry_q, 2'b00});
            state_d = StLaunch;
          end else begin
            state_d = StError;
          end
        end
      end
      StLaunch: state_d = StDone;
      StDone, StError: begin
        if (clear) begin
          state_d   = StIdle;
          count_d   = '0;
          entry_d   = '0;
          hdr_cnt_d = '0;
          index_d   = '0;
          csum_d    = '0;
          addr_d    = '0;
          prog_d    = '0;
        end
      end
      default: state_d = StError;
    endcase

    // Flags are registered copies decoded from the next state.
    rx_ready_d   = (state_d == StIdle) | (state_d == StHdr) | (state_d == StData) |
                   (state_d == StCsum);
    busy_d       = (state_d == StHdr) | (state_d == StData) | (state_d == StWrite) |
                   (state_d == StCsum) | (state_d == StLaunch);
    core_reset_d = (state_d == StHdr) | (state_d == StData) | (state_d == StWrite) |
                   (state_d == StCsum) | (state_d == StError);
    start_d      = (state_d == StLaunch);
    done_d       = (state_d == StDone);
    error_d      = (state_d == StError);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      count_q      <= '0;
      entry_q      <= '0;
      hdr_cnt_q    <= '0;
      index_q      <= '0;
      csum_q       <= '0;
      addr_q       <= '0;
      prog_q       <= '0;
      rx_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      core_reset_q <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      entry_q      <= entry_d;
      hdr_cnt_q    <= hdr_cnt_d;
      index_q      <= index_d;
      csum_q       <= csum_d;
      addr_q       <= addr_d;
      prog_q       <= prog_d;
      rx_ready_q   <= rx_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      core_reset_q <= core_reset_d;
      start_q      <= start_d;
    end
  end

  assign bus.rx_ready     = rx_ready_q;
  assign bus.isp_write    = asm_word_valid;
  assign bus.isp_address  = addr_q;
  assign bus.isp_data     = DATA_WIDTH'(asm_word);
  assign bus.core_reset   = core_reset_q;
  assign bus.start        = start_q;
  assign bus.prog_address = prog_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;

endmodule

// File: tb/tb_isp_program_loader.sv
// Randomized frame bench for isp_program_loader with a frame-level reference model.
module tb_isp_program_loader;

  localparam int unsigned AB    = 12;
  localparam int unsigned DEPTH = 1 << AB;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  logic busy, done, error;

  isp_program_loader_if #(.DATA_WIDTH(32), .ADDRESS_BITS(AB)) bus ();

  isp_program_loader #(.DATA_WIDTH(32), .ADDRESS_BITS(AB)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus),
    .clear(clear),
    .busy (busy),
    .done (done),
    .error(error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed writes and launches.
  logic [AB-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];
  int            start_cnt = 0;
  logic [19:0]   start_prog = '0;
  logic          start_cr = 1'b1;

  always @(negedge clock) begin
    if (bus.isp_write) begin
      wr_addr_q.push_back(bus.isp_address);
      wr_data_q.push_back(bus.isp_data);
    end
    if (bus.start) begin
      start_cnt++;
      start_prog = bus.prog_address;
      start_cr   = bus.core_reset;
    end
  end

  logic [31:0] frame_words[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps && $urandom_range(0, 3) == 0) begin
      bus.rx_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clock);
      #1;
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clock);
      if (bus.rx_ready) begin
        @(posedge clock);
        #1;
        break;
      end
      t++;
      if (t > 50) begin
        check_eq("rx_ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  // Sends one frame built from frame_words and checks the outcome against the frame rules.
  task automatic run_frame(input logic [15:0] cnt, input logic [15:0] entry,
                           input logic [7:0] corrupt, input bit gaps);
    logic [7:0]  bytes[$];
    logic [7:0]  x;
    logic [31:0] w;
    bit          bad_hdr, exp_ok;
    int          wb, sb, n, waited;
    bad_hdr = (int'(cnt) > int'(DEPTH)) || (int'(entry) >= int'(DEPTH));
    exp_ok  = !bad_hdr && (corrupt == 8'h00);
    bytes   = '{cnt[7:0], cnt[15:8], entry[7:0], entry[15:8]};
    if (!bad_hdr) begin
      for (int i = 0; i < int'(cnt); i++) begin
        w = frame_words[i];
        for (int b = 0; b < 4; b++) bytes.push_back(w[8*b +: 8]);
      end
      x = 8'h00;
      foreach (bytes[i]) x ^= bytes[i];
      bytes.push_back(x ^ corrupt);
    end
    wb = wr_addr_q.size();
    sb = start_cnt;
    foreach (bytes[i]) begin
      send_byte(bytes[i], gaps);
      if (i == 0) begin
        check_eq("core_reset_after_hdr0", 32'(bus.core_reset), 32'd1);
        check_eq("busy_after_hdr0", 32'(busy), 32'd1);
      end
      if (bad_hdr && i == 3) check_eq("error_after_hdr", 32'(error), 32'd1);
    end
    bus.rx_valid = 1'b0;
    waited = 0;
    while (!(done || error) && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    check_eq("finish_within_budget", 32'(done | error), 32'd1);
    repeat (2) @(negedge clock);
    check_eq("done", 32'(done), 32'(exp_ok));
    check_eq("error", 32'(error), 32'(!exp_ok));
    check_eq("busy_end", 32'(busy), 32'd0);
    check_eq("core_reset_end", 32'(bus.core_reset), 32'(!exp_ok));
    check_eq("rx_ready_end", 32'(bus.rx_ready), 32'd0);
    check_eq("start_pulses", 32'(start_cnt - sb), 32'(exp_ok));
    if (exp_ok) begin
      check_eq("start_prog", 32'(start_prog), 32'(entry) * 4);
      check_eq("core_reset_at_start", 32'(start_cr), 32'd0);
    end
    check_eq("prog_hold", 32'(bus.prog_address), exp_ok ? 32'(entry) * 4 : 32'd0);
    n = wr_addr_q.size() - wb;
    check_eq("num_writes", 32'(n), bad_hdr ? 32'd0 : 32'(cnt));
    for (int i = 0; i < n && i < int'(cnt) && !bad_hdr; i++) begin
      check_eq("wr_addr", 32'(wr_addr_q[wb+i]), 32'(i));
      check_eq("wr_data", wr_data_q[wb+i], frame_words[i]);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    check_eq("clr_rx_ready", 32'(bus.rx_ready), 32'd1);
    check_eq("clr_flags", {29'd0, busy, done, error}, 32'd0);
    check_eq("clr_core_reset", 32'(bus.core_reset), 32'd0);
    check_eq("clr_prog", 32'(bus.prog_address), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
    check_eq({tag, "_flags"}, {26'd0, busy, done, error, bus.isp_write, bus.start,
                               bus.core_reset}, 32'd0);
    check_eq({tag, "_addr"}, 32'(bus.isp_address), 32'd0);
    check_eq({tag, "_data"}, bus.isp_data, 32'd0);
    check_eq({tag, "_prog"}, 32'(bus.prog_address), 32'd0);
  endtask

  initial begin
    logic [15:0] cnt, entry;
    logic [7:0]  corrupt;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    #12;
    check_reset_state("reset");
    #8 reset = 1'b1;  // released on a falling edge
    @(posedge clock);
    #1;

    // Basic single-word load.
    frame_words = '{32'h0000_0013};
    run_frame(16'd1, 16'd0, 8'h00, 1'b0);
    do_clear();

    // Two words, entry 1; rx_valid stays high across each WRITE cycle.
    frame_words = '{32'h0010_0093, 32'h0020_0113};
    run_frame(16'd2, 16'd1, 8'h00, 1'b0);
    do_clear();

    // Bad checksum (0x13 instead of 0x12).
    frame_words = '{32'h0000_0013};
    run_frame(16'd1, 16'd0, 8'h01, 1'b0);
    do_clear();

    // Oversize count and out-of-range entry.
    run_frame(16'h1001, 16'd0, 8'h00, 1'b0);
    do_clear();
    run_frame(16'd1, 16'd4096, 8'h00, 1'b0);
    do_clear();

    // Empty image: header then checksum only.
    frame_words.delete();
    run_frame(16'd0, 16'd5, 8'h00, 1'b0);
    do_clear();

    // Full-depth image with the highest legal entry.
    frame_words.delete();
    for (int i = 0; i < int'(DEPTH); i++) frame_words.push_back($urandom);
    run_frame(16'(DEPTH), 16'(DEPTH - 1), 8'h00, 1'b0);
    do_clear();

    // Async reset in the middle of the payload, then a fresh frame.
    frame_words = '{32'hdead_beef, 32'h1234_5678, 32'h0bad_f00d};
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hef, 1'b0);
    send_byte(8'hbe, 1'b0);
    #2 reset = 1'b0;
    #1;
    check_reset_state("midreset");
    bus.rx_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    run_frame(16'd3, 16'd7, 8'h00, 1'b1);
    do_clear();

    // Randomized frames.
    for (int f = 0; f < 12; f++) begin
      cnt = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 9) == 0) cnt = 16'($urandom_range(DEPTH + 1, 65535));
      entry = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(DEPTH, 65535))
                                          : 16'($urandom_range(0, DEPTH - 1));
      corrupt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      frame_words.delete();
      for (int i = 0; i < 6; i++) frame_words.push_back($urandom);
      run_frame(cnt, entry, corrupt, 1'b1);
      do_clear();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
